// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states, opcodes,
// ALU control codes and datapath mux select codes.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecuteR = 4'd7,
    StExecuteI = 4'd8,
    StAluWb    = 4'd9,
    StBeq      = 4'd10,
    StJal      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic is_legal_op(logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
           (op == OP_JAL) || (op == OP_BEQ);
  endfunction

  function automatic logic [1:0] imm_src_of(logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct to ALUControl mapping. op5 separates R-type sub from
// I-type addi, which shares funct3 000 but has no subtract form.
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    unique case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback and
// decodes Moore-style datapath controls from the current state.
module control_unit_mc
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic       done
);

  state_t     state_q;
  logic       pc_update, branch, mem_write, ir_write, reg_write, illegal_raw, done_raw;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StReset;
    end else begin
      case (state_q)
        StReset:  state_q <= StFetch;
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (op)
            OP_LW, OP_SW: state_q <= StMemAdr;
            OP_R:         state_q <= StExecuteR;
            OP_I:         state_q <= StExecuteI;
            OP_JAL:       state_q <= StJal;
            OP_BEQ:       state_q <= StBeq;
            default:      state_q <= StFetch;
          endcase
        end
        StMemAdr:                              state_q <= (op == OP_SW) ? StMemWrite : StMemRead;
        StMemRead:                             state_q <= StMemWb;
        StMemWb, StMemWrite, StAluWb, StBeq:   state_q <= StFetch;
        StExecuteR, StExecuteI, StJal:         state_q <= StAluWb;
        default:                               state_q <= StReset;
      endcase
    end
  end

  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal_raw = 1'b0;
    done_raw    = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      StFetch: begin
        ir_write  = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      StDecode: begin
        // Branch target is precomputed here from OldPC + ImmExt.
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_IMM;
        illegal_raw = ~is_legal_op(op);
        done_raw    = ~is_legal_op(op);
      end
      StMemAdr: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        done_raw  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done_raw  = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      StExecuteI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      StAluWb: begin
        reg_write = 1'b1;
        done_raw  = 1'b1;
      end
      StBeq: begin
        ALUSrcA  = SRCA_RD1;
        alu_op   = ALUOP_SUB;
        branch   = 1'b1;
        done_raw = 1'b1;
      end
      StJal: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked by rst_n so a mid-instruction reset cannot commit state.
  assign PCWrite  = rst_n & ((branch & zero) | pc_update);
  assign MemWrite = rst_n & mem_write;
  assign IRWrite  = rst_n & ir_write;
  assign RegWrite = rst_n & reg_write;
  assign illegal  = rst_n & illegal_raw;
  assign done     = rst_n & done_raw;

  assign ImmSrc = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc: per-cycle outputs compared against a
// table-driven model of each instruction's phase sequence.
module tb_control_unit_mc;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpBad = 7'b1111111;

  typedef enum int {
    PReset, PFetch, PDecode, PMemAdr, PMemRead, PMemWb, PMemWrite,
    PExecR, PExecI, PAluWb, PBeq, PJal
  } phase_e;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] ressrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] immsrc;
    logic [2:0] aluctl;
    logic       illegal;
    logic       done;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, done;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  outs_t      obs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_unit_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal    (illegal),
    .done       (done)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, illegal, done};

  function automatic logic legal(logic [6:0] o);
    return o == OpLw || o == OpSw || o == OpR || o == OpI || o == OpJal || o == OpBeq;
  endfunction

  // Instruction latency, FETCH inclusive.
  function automatic int seq_len_of(logic [6:0] o);
    if (o == OpLw) return 5;
    if (o == OpBeq) return 3;
    if (legal(o)) return 4;
    return 2;
  endfunction

  function automatic phase_e phase_at(logic [6:0] o, int c);
    if (c == 0) return PFetch;
    if (c == 1) return PDecode;
    if (o == OpLw) return (c == 2) ? PMemAdr : (c == 3) ? PMemRead : PMemWb;
    if (o == OpSw) return (c == 2) ? PMemAdr : PMemWrite;
    if (o == OpR) return (c == 2) ? PExecR : PAluWb;
    if (o == OpI) return (c == 2) ? PExecI : PAluWb;
    if (o == OpJal) return (c == 2) ? PJal : PAluWb;
    return PBeq;
  endfunction

  function automatic logic [2:0] alu_ref(logic [1:0] aop, logic [6:0] o, logic [2:0] f3,
                                         logic f7);
    if (aop == 2'b00) return 3'b000;
    if (aop == 2'b01) return 3'b001;
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outs_t model(phase_e ph, logic [6:0] o, logic [2:0] f3, logic f7,
                                  logic z, logic rst_low);
    outs_t      e;
    logic [1:0] aop;
    logic       pcupd, br;
    e = '0;
    aop = 2'b00;
    pcupd = 1'b0;
    br = 1'b0;
    if (o == OpSw) e.immsrc = 2'b01;
    else if (o == OpBeq) e.immsrc = 2'b10;
    else if (o == OpJal) e.immsrc = 2'b11;
    case (ph)
      PFetch:    begin e.irwrite = 1; pcupd = 1; e.srcb = 2'b10; e.ressrc = 2'b10; end
      PDecode:   begin
        e.srca = 2'b01; e.srcb = 2'b01;
        if (!legal(o)) begin e.illegal = 1; e.done = 1; end
      end
      PMemAdr:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      PMemRead:  e.adrsrc = 1;
      PMemWb:    begin e.ressrc = 2'b01; e.regwrite = 1; e.done = 1; end
      PMemWrite: begin e.adrsrc = 1; e.memwrite = 1; e.done = 1; end
      PExecR:    begin e.srca = 2'b10; aop = 2'b10; end
      PExecI:    begin e.srca = 2'b10; e.srcb = 2'b01; aop = 2'b10; end
      PAluWb:    begin e.regwrite = 1; e.done = 1; end
      PBeq:      begin e.srca = 2'b10; aop = 2'b01; br = 1; e.done = 1; end
      PJal:      begin e.srca = 2'b01; e.srcb = 2'b10; pcupd = 1; end
      default:   ;
    endcase
    e.pcwrite = (br && z) || pcupd;
    e.aluctl = alu_ref(aop, o, f3, f7);
    if (rst_low) begin
      e.pcwrite = 0; e.memwrite = 0; e.irwrite = 0; e.regwrite = 0; e.illegal = 0; e.done = 0;
    end
    return e;
  endfunction

  task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    zero = z;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    outs_t e;
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e = model(PReset, op, funct3, funct7b5, zero, 1'b1);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_held c%0d got=%h exp=%h", c, obs, e);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    e = model(PReset, op, funct3, funct7b5, zero, 1'b0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_released got=%h exp=%h", obs, e);
    end
    next_cycle();
  endtask

  task automatic test_rtype();
    outs_t e;
    set_instr(OpR, 3'b000, 1'b1, 1'b0);
    for (int c = 0; c < seq_len_of(OpR); c++) begin
      @(negedge clk);
      e = model(phase_at(OpR, c), op, funct3, funct7b5, zero, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rtype_sub c%0d got=%h exp=%h", c, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_lw();
    outs_t e;
    set_instr(OpLw, 3'b010, 1'b1, 1'b1);
    for (int c = 0; c < seq_len_of(OpLw); c++) begin
      @(negedge clk);
      e = model(phase_at(OpLw, c), op, funct3, funct7b5, zero, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL lw c%0d got=%h exp=%h", c, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_sw();
    outs_t e;
    int    mw_cycles = 0;
    set_instr(OpSw, 3'b010, 1'b0, 1'b0);
    for (int c = 0; c < seq_len_of(OpSw); c++) begin
      @(negedge clk);
      e = model(phase_at(OpSw, c), op, funct3, funct7b5, zero, 1'b0);
      if (MemWrite === 1'b1) mw_cycles++;
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL sw c%0d got=%h exp=%h", c, obs, e);
      end
      next_cycle();
    end
    n_checks++;
    if (mw_cycles !== 1) begin
      n_fail++;
      $display("FAIL sw_memwrite_cycles got=%0d exp=1", mw_cycles);
    end
  endtask

  task automatic test_beq(logic z);
    outs_t e;
    set_instr(OpBeq, 3'b001, 1'b1, z);
    for (int c = 0; c < seq_len_of(OpBeq); c++) begin
      @(negedge clk);
      e = model(phase_at(OpBeq, c), op, funct3, funct7b5, zero, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL beq_zero%0d c%0d got=%h exp=%h", z, c, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    outs_t e;
    set_instr(OpBad, 3'b111, 1'b1, 1'b1);
    for (int c = 0; c < seq_len_of(OpBad); c++) begin
      @(negedge clk);
      e = model(phase_at(OpBad, c), op, funct3, funct7b5, zero, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL illegal c%0d got=%h exp=%h", c, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_lw();
    outs_t e;
    set_instr(OpLw, 3'b010, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = model(phase_at(OpLw, c), op, funct3, funct7b5, zero, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL midlw_pre c%0d got=%h exp=%h", c, obs, e);
      end
      next_cycle();
    end
    rst_n = 1'b0;
    @(negedge clk);
    e = model(PMemRead, op, funct3, funct7b5, zero, 1'b1);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL midlw_reset_asserted got=%h exp=%h", obs, e);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    e = model(PReset, op, funct3, funct7b5, zero, 1'b0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL midlw_reset_state got=%h exp=%h", obs, e);
    end
    next_cycle();
    @(negedge clk);
    e = model(PFetch, op, funct3, funct7b5, zero, 1'b0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL midlw_refetch got=%h exp=%h", obs, e);
    end
    next_cycle();
    // Finish the restarted lw from DECODE onward.
    for (int c = 1; c < seq_len_of(OpLw); c++) begin
      @(negedge clk);
      e = model(phase_at(OpLw, c), op, funct3, funct7b5, zero, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL midlw_restart c%0d got=%h exp=%h", c, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    outs_t      e;
    logic [6:0] ops [6];
    logic [6:0] o;
    int         sel;
    ops[0] = OpLw; ops[1] = OpSw; ops[2] = OpR; ops[3] = OpI; ops[4] = OpJal; ops[5] = OpBeq;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      if (sel < 6) o = ops[sel];
      else if (sel == 6) o = OpBad;
      else o = 7'($urandom);
      set_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      for (int c = 0; c < seq_len_of(o); c++) begin
        @(negedge clk);
        e = model(phase_at(o, c), op, funct3, funct7b5, zero, 1'b0);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL b2b n%0d op=%b f3=%b f7=%b z=%b c%0d got=%h exp=%h",
                   n, op, funct3, funct7b5, zero, c, obs, e);
        end
        next_cycle();
      end
    end
    @(negedge clk);
    e = model(PFetch, op, funct3, funct7b5, zero, 1'b0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL b2b_final_fetch got=%h exp=%h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal();
    test_reset_mid_lw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
